onehot_ring_monitor: RTL and testbench

//  Receive-side checker for a one-hot ring counter (e.g. a 2-bit counter driving a 2:4 decoder).

---
 rtl/onehot_ring_monitor.sv | 163 ++++++++++++++++
 tb/tb_onehot_ring_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_ring_monitor.sv
// onehot_ring_monitor
//   Receive-side health monitor for a one-hot ring counter. It samples the
//   phase bus and converts it back to a binary index. It checks that exactly
//   one bit is hot and that each sample advances by one (mod N). Once lock is
//   acquired, it flags and counts sequencing errors.
//
// Ports
//   clock      in   1     clock, all state updates on posedge
//   Resetn     in   1     synchronous active-low reset
//   en         in   1     sample strobe; onehot_in is examined only when en=1
//   onehot_in  in   N     phase bus from the ring counter
//   clr_err    in   1     synchronous clear of err_count
//   idx_out    out  W     binary index of the last legal sample
//   valid      out  1     one-cycle pulse after a legal sample
//   locked     out  1     monitor is in LOCKED
//   err_pulse  out  1     one-cycle pulse after an error seen while LOCKED
//   err_count  out  ERRW  saturating error count
//
// state  | meaning
// HUNT   | no usable history; waiting for any legal sample
// ACQ    | tracking; counting consecutive correct advances toward lock
// LOCKED | sequence trusted; deviations are errors
module onehot_ring_monitor #(
  parameter int N        = 4,
  parameter int W        = $clog2(N),
  parameter int LOCK_CNT = 2,
  parameter int ERRW     = 8
) (
  input  logic            clock,
  input  logic            Resetn,
  input  logic            en,
  input  logic [N-1:0]    onehot_in,
  input  logic            clr_err,
  output logic [W-1:0]    idx_out,
  output logic            valid,
  output logic            locked,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count
);

  localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]   LOCK_G  = GW'(LOCK_CNT);
  localparam logic [W-1:0]    LAST    = W'(N - 1);
  localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    prev_q, prev_d;
  logic [GW-1:0]   good_q, good_d;
  logic [W-1:0]    idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [ERRW-1:0] cnt_q, cnt_d;

  logic [W:0]      ones;
  logic [W-1:0]    idx;
  logic            legal;
  logic [W-1:0]    expected;
  logic            match;

  // ones is one bit wider than the index, so it can count all N bits.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + (W+1)'(onehot_in[i]);
      if (onehot_in[i]) idx = W'(i);
    end
    legal    = (ones == (W+1)'(1));
    expected = (prev_q == LAST) ? '0 : prev_q + W'(1);
    match    = (idx == expected);
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (en) begin
      if (legal) begin
        valid_d = 1'b1;
        idx_d   = idx;
      end
      case (state_q)
        HUNT: begin
          if (legal) begin
            state_d = ACQ;
            prev_d  = idx;
            good_d  = '0;
          end
        end
        ACQ: begin
          if (!legal) begin
            state_d = HUNT;
          end else if (match) begin
            prev_d = idx;
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == LOCK_G) state_d = LOCKED;
          end else begin
            prev_d = idx;
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!legal) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (!match) begin
            err_d   = 1'b1;
            state_d = ACQ;
            prev_d  = idx;
            good_d  = '0;
          end else begin
            prev_d = idx;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // A clear that lands on the same edge as an error keeps that error.
    if (clr_err)
      cnt_d = err_d ? ERRW'(1) : '0;
    else if (err_d && cnt_q != ERR_MAX)
      cnt_d = cnt_q + ERRW'(1);
  end

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      state_q <= HUNT;
      prev_q  <= '0;
      good_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      good_q  <= good_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx_out   = idx_q;
  assign valid     = valid_q;
  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_onehot_ring_monitor.sv
// Testbench for onehot_ring_monitor. Two instances share the same stimulus:
// dut8 uses ERRW=8 and dut2 uses ERRW=2, which exercises saturation.
module tb_onehot_ring_monitor;

  logic       clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       en = 1'b0;
  logic [3:0] onehot_in = 4'b0000;
  logic       clr_err = 1'b0;

  logic [1:0] idx8, idx2;
  logic       valid8, valid2, locked8, locked2, errp8, errp2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  onehot_ring_monitor #(.N(4), .W(2), .LOCK_CNT(2), .ERRW(8)) dut8 (
    .clock(clock), .Resetn(Resetn), .en(en), .onehot_in(onehot_in),
    .clr_err(clr_err), .idx_out(idx8), .valid(valid8), .locked(locked8),
    .err_pulse(errp8), .err_count(cnt8));

  onehot_ring_monitor #(.N(4), .W(2), .LOCK_CNT(2), .ERRW(2)) dut2 (
    .clock(clock), .Resetn(Resetn), .en(en), .onehot_in(onehot_in),
    .clr_err(clr_err), .idx_out(idx2), .valid(valid2), .locked(locked2),
    .err_pulse(errp2), .err_count(cnt2));

  typedef struct {
    int idx;
    int valid;
    int locked;
    int errp;
    int c8;
    int c2;
  } exp_t;

  exp_t sb[$];

  // reference model state: 0=HUNT 1=ACQ 2=LOCKED
  int ms = 0, mprev = 0, mgood = 0, midx = 0, mc8 = 0, mc2 = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic e, input logic [3:0] oh,
                      input logic clr);
    exp_t x;
    int   v, err, legal, id, nxt;
    @(negedge clock);
    Resetn    = rst_n;
    en        = e;
    onehot_in = oh;
    clr_err   = clr;
    v = 0; err = 0;
    if (!rst_n) begin
      ms = 0; mprev = 0; mgood = 0; midx = 0; mc8 = 0; mc2 = 0;
    end else begin
      if (e) begin
        legal = ($countones(oh) == 1) ? 1 : 0;
        id    = legal ? $clog2(oh) : 0;
        nxt   = (mprev + 1) % 4;
        if (legal) begin v = 1; midx = id; end
        if (ms == 0) begin
          if (legal) begin ms = 1; mprev = id; mgood = 0; end
        end else if (!legal) begin
          if (ms == 2) err = 1;
          ms = 0;
        end else if (id == nxt) begin
          mprev = id;
          if (ms == 1) begin
            mgood++;
            if (mgood == 2) ms = 2;
          end
        end else begin
          if (ms == 2) err = 1;
          ms = 1; mprev = id; mgood = 0;
        end
      end
      if (clr) begin
        mc8 = err; mc2 = err;
      end else if (err != 0) begin
        if (mc8 < 255) mc8++;
        if (mc2 < 3) mc2++;
      end
    end
    x.idx = midx; x.valid = v; x.locked = (ms == 2) ? 1 : 0; x.errp = err;
    x.c8 = mc8; x.c2 = mc2;
    sb.push_back(x);

    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      x = sb.pop_front();
      chk("idx_out",   int'(idx8),    x.idx);
      chk("valid",     int'(valid8),  x.valid);
      chk("locked",    int'(locked8), x.locked);
      chk("err_pulse", int'(errp8),   x.errp);
      chk("err_count", int'(cnt8),    x.c8);
      chk("err_count_sat", int'(cnt2), x.c2);
      chk("idx_out_w2", int'(idx2),   x.idx);
      chk("locked_w2",  int'(locked2), x.locked);
    end
  endtask

  logic [3:0] ph;

  initial begin
    // Reset with active inputs present.
    step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b0010, 0);
    chk("rst_idx", int'(idx8), 0);
    chk("rst_valid", int'(valid8), 0);
    chk("rst_locked", int'(locked8), 0);
    chk("rst_cnt", int'(cnt8), 0);

    // Acquire lock.
    step(1, 1, 4'b0001, 0);
    chk("lock_n1", int'(locked8), 0);
    step(1, 1, 4'b0010, 0);
    chk("lock_n2", int'(locked8), 0);
    step(1, 1, 4'b0100, 0);
    chk("lock_n3", int'(locked8), 1);
    chk("lock_idx", int'(idx8), 2);

    // Wrap-around 3 -> 0 while locked.
    step(1, 1, 4'b1000, 0);
    step(1, 1, 4'b0001, 0);
    chk("wrap_idx", int'(idx8), 0);
    chk("wrap_locked", int'(locked8), 1);
    chk("wrap_errp", int'(errp8), 0);

    // Skip from idx1 to idx3.
    step(1, 1, 4'b0010, 0);
    step(1, 1, 4'b1000, 0);
    chk("skip_errp", int'(errp8), 1);
    chk("skip_cnt", int'(cnt8), 1);
    chk("skip_locked", int'(locked8), 0);
    chk("skip_idx", int'(idx8), 3);
    step(1, 1, 4'b0001, 0);
    chk("skip_errp_once", int'(errp8), 0);
    step(1, 1, 4'b0010, 0);
    chk("relock", int'(locked8), 1);

    // Illegal sample while locked, followed by en gaps with garbage.
    step(1, 1, 4'b0110, 0);
    chk("ill_valid", int'(valid8), 0);
    chk("ill_idx", int'(idx8), 1);
    chk("ill_cnt", int'(cnt8), 2);
    step(1, 0, 4'b1111, 0);
    step(1, 0, 4'b0000, 0);
    step(1, 0, 4'b0101, 0);
    chk("gap_cnt", int'(cnt8), 2);
    chk("gap_idx", int'(idx8), 1);

    // More locked errors saturate the 2-bit counter.
    step(1, 1, 4'b0001, 0);
    step(1, 1, 4'b0010, 0);
    step(1, 1, 4'b0100, 0);
    step(1, 1, 4'b0000, 0);
    step(1, 1, 4'b0001, 0);
    step(1, 1, 4'b0010, 0);
    step(1, 1, 4'b0100, 0);
    step(1, 1, 4'b0001, 0);
    chk("sat_cnt2", int'(cnt2), 3);
    chk("sat_cnt8", int'(cnt8), 4);
    step(1, 1, 4'b0010, 0);
    step(1, 1, 4'b0100, 0);
    step(1, 1, 4'b0001, 1);
    chk("clr_err_coinc", int'(cnt2), 1);
    step(1, 1, 4'b0010, 1);
    chk("clr_alone", int'(cnt8), 0);

    // Mid-operation reset.
    step(1, 1, 4'b0100, 0);
    step(1, 1, 4'b1000, 0);
    step(0, 1, 4'b0001, 1);
    chk("midrst_locked", int'(locked8), 0);

    // Mostly-correct random sequence with occasional faults and gaps.
    ph = 4'b0001;
    for (int i = 0; i < 200; i++) begin
      logic [3:0] d;
      if ($urandom_range(0, 9) < 8) d = ph;
      else d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 8) ph = {ph[2:0], ph[3]};
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 8), d,
           ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
